// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit controller.
//   state_t      : transmit sequencer states
//   *_OFF        : word offsets on the peripherals bus
//   ST_* / CT_*  : bit positions inside STATUS and CTRL
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [1:0] TXDATA_OFF = 2'd0;
    localparam logic [1:0] STATUS_OFF = 2'd1;
    localparam logic [1:0] CTRL_OFF   = 2'd2;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CT_ENABLE  = 0;
    localparam int CT_IRQ_EN  = 1;
    localparam int CT_BLOCK   = 2;
    localparam int CT_CLR_OVF = 3;
    localparam int CT_FLUSH   = 4;

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// Synchronous FIFO with wrap-around pointers carrying an extra MSB so that
// full and empty are distinguished without a separate counter.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i, wr_data_i  : write request and data
//   pop_i              : remove head entry
//   flush_i            : discard all entries (wins over push/pop)
//   rd_data_o          : head entry, combinational
//   full_o, empty_o    : occupancy flags
//   count_o            : number of stored entries
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNTW  = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNTW-1:0]  count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CNTW-1:0]  w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == CNTW'(DEPTH));
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_pop  = pop_i & ~w_empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_do_push = push_i & (~w_full | w_do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = r_mem[r_rd_ptr[AW-1:0]];
    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign count_o   = w_count;

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped transmit controller between the peripherals bus and uart_tx.
// Stores bytes in a FIFO and hands them to uart_tx one at a time.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cs_i, we_i, addr_i  : bus select, store strobe, word offset
//   wdata_i / rdata_o   : store data / load data (0 when not selected)
//   stall_o             : hold the pipeline on a blocked TXDATA store
//   irq_o               : TX-empty interrupt (level, registered)
//   tx_*                : handshake with uart_tx
//
// state | meaning
// IDLE  | waiting for enable and a queued byte
// LOAD  | head byte presented, byte_ready strobe, FIFO pop
// START | t_byte start strobe
// WAIT  | byte on the wire, waiting for tx_done_i
module uart_tx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DW      = 32,
    parameter int DEPTH   = 8,
    parameter int DW_UART = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cs_i,
    input  logic               we_i,
    input  logic [1:0]         addr_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o,
    output logic               stall_o,
    output logic               irq_o,
    output logic [DW_UART-1:0] tx_data_o,
    output logic               tx_cs_o,
    output logic               tx_byte_ready_o,
    output logic               tx_start_o,
    input  logic               tx_done_i
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_en;
    logic               r_irq_en;
    logic               r_block;
    logic               r_ovf;
    logic               r_irq;
    logic [DW_UART-1:0] r_tx_data;

    logic               w_wr_tx;
    logic               w_wr_ctrl;
    logic               w_flush;
    logic               w_clr_ovf;
    logic               w_pop;
    logic               w_can_push;
    logic               w_push;
    logic               w_drop;
    logic               w_go;
    logic               w_busy;
    logic               w_tx_cs;
    logic               w_tx_br;
    logic               w_tx_start;
    logic [DW_UART-1:0] w_fifo_rd_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNTW-1:0]    w_fifo_count;
    logic [DW-1:0]      w_status;
    logic [DW-1:0]      w_ctrl;
    logic               w_unused;

    assign w_unused = ^wdata_i[DW-1:DW_UART];

    assign w_wr_tx    = cs_i & we_i & (addr_i == TXDATA_OFF);
    assign w_wr_ctrl  = cs_i & we_i & (addr_i == CTRL_OFF);
    assign w_flush    = w_wr_ctrl & wdata_i[CT_FLUSH];
    assign w_clr_ovf  = w_wr_ctrl & wdata_i[CT_CLR_OVF];
    assign w_pop      = (r_state == LOAD);
    assign w_can_push = ~w_fifo_full | w_pop;
    assign w_push     = w_wr_tx & w_can_push & ~w_flush;
    assign w_drop     = w_wr_tx & ~w_can_push & ~r_block;
    assign stall_o    = w_wr_tx & ~w_can_push & r_block;
    assign w_busy     = (r_state != IDLE);
    // A flush in the same cycle would leave LOAD with nothing to pop.
    assign w_go       = r_en & ~w_fifo_empty & ~w_flush;

    sync_fifo #(
        .WIDTH (DW_UART),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (w_push),
        .pop_i     (w_pop),
        .flush_i   (w_flush),
        .wr_data_i (wdata_i[DW_UART-1:0]),
        .rd_data_o (w_fifo_rd_data),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty),
        .count_o   (w_fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_en      <= 1'b1;
            r_irq_en  <= 1'b0;
            r_block   <= 1'b0;
            r_ovf     <= 1'b0;
            r_irq     <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_ctrl) begin
                r_en     <= wdata_i[CT_ENABLE];
                r_irq_en <= wdata_i[CT_IRQ_EN];
                r_block  <= wdata_i[CT_BLOCK];
            end
            if (w_clr_ovf)   r_ovf <= 1'b0;
            else if (w_drop) r_ovf <= 1'b1;
            r_irq <= r_irq_en & w_fifo_empty & ~w_busy;
            // Capture the head on entry to LOAD so tx_data_o is valid through WAIT.
            if (r_state == IDLE && w_go) r_tx_data <= w_fifo_rd_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_cs     = 1'b0;
        w_tx_br     = 1'b0;
        w_tx_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_tx_cs     = 1'b1;
                w_tx_br     = 1'b1;
                w_state_nxt = START;
            end
            START: begin
                w_tx_cs     = 1'b1;
                w_tx_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_tx_cs = 1'b1;
                if (tx_done_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_status                               = '0;
        w_status[ST_EMPTY]                     = w_fifo_empty;
        w_status[ST_FULL]                      = w_fifo_full;
        w_status[ST_BUSY]                      = w_busy;
        w_status[ST_OVF]                       = r_ovf;
        w_status[ST_COUNT_LSB +: CNTW]         = w_fifo_count;
        w_ctrl                                 = '0;
        w_ctrl[CT_ENABLE]                      = r_en;
        w_ctrl[CT_IRQ_EN]                      = r_irq_en;
        w_ctrl[CT_BLOCK]                       = r_block;
    end

    always_comb begin
        rdata_o = '0;
        if (cs_i) begin
            case (addr_i)
                STATUS_OFF: rdata_o = w_status;
                CTRL_OFF:   rdata_o = w_ctrl;
                default:    rdata_o = '0;
            endcase
        end
    end

    assign irq_o           = r_irq;
    assign tx_data_o       = r_tx_data;
    assign tx_cs_o         = w_tx_cs;
    assign tx_byte_ready_o = w_tx_br;
    assign tx_start_o      = w_tx_start;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  addr_i = 2'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        irq_o;
    logic [7:0]  tx_data_o;
    logic        tx_cs_o;
    logic        tx_byte_ready_o;
    logic        tx_start_o;
    logic        tx_done_i = 1'b0;

    uart_tx_ctrl #(.DW(32), .DEPTH(8), .DW_UART(8)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cs_i            (cs_i),
        .we_i            (we_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .rdata_o         (rdata_o),
        .stall_o         (stall_o),
        .irq_o           (irq_o),
        .tx_data_o       (tx_data_o),
        .tx_cs_o         (tx_cs_o),
        .tx_byte_ready_o (tx_byte_ready_o),
        .tx_start_o      (tx_start_o),
        .tx_done_i       (tx_done_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [7:0] sb_q[$];
    logic [7:0] cur_byte = 8'd0;
    int  last_br_cyc = -100;
    int  last_done_cyc = -100;
    int  n_loads = 0;
    bit  gap_mode = 1'b0;
    int  gap_dones = 0;
    bit  prev_br = 1'b0;

    // Output monitor: every load is scored against the queue of accepted bytes.
    always @(negedge clk_i) begin
        if (tx_byte_ready_o) begin
            n_loads++;
            chk("br_single_pulse", 32'(prev_br), 32'd0);
            chk("br_cs", 32'(tx_cs_o), 32'd1);
            if (sb_q.size() == 0) chk("unexpected_load", 32'(sb_q.size() != 0), 32'd1);
            else chk("tx_data_order", 32'(tx_data_o), 32'(sb_q.pop_front()));
            cur_byte    = tx_data_o;
            last_br_cyc = cyc;
        end
        if (tx_start_o) begin
            chk("start_after_ready", 32'(cyc - last_br_cyc), 32'd1);
            chk("data_stable", 32'(tx_data_o), 32'(cur_byte));
            chk("start_cs", 32'(tx_cs_o), 32'd1);
            if (gap_mode && gap_dones > 0) chk("b2b_gap", 32'(cyc - last_done_cyc), 32'd3);
        end
        prev_br = tx_byte_ready_o;
    end

    // uart_tx model: done pulse 20 cycles after each start strobe.
    always begin
        @(negedge clk_i);
        if (tx_start_o) begin
            repeat (20) @(negedge clk_i);
            tx_done_i     = 1'b1;
            last_done_cyc = cyc;
            if (gap_mode) gap_dones++;
            @(negedge clk_i);
            tx_done_i = 1'b0;
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_i);
        cs_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(negedge clk_i);
        cs_i = 1'b0; we_i = 1'b0; addr_i = 2'd0; wdata_i = 32'd0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_i);
        cs_i = 1'b1; we_i = 1'b0; addr_i = a;
        #1;
        d = rdata_o;
        cs_i = 1'b0; addr_i = 2'd0;
    endtask

    task automatic wait_status(input logic [31:0] exp, input int budget, input string tag);
        logic [31:0] s;
        s = 32'hDEAD_BEEF;
        for (int i = 0; i < budget; i++) begin
            bus_rd(2'd1, s);
            if (s == exp) break;
        end
        chk(tag, s, exp);
    endtask

    logic [31:0] rd;
    int          w;
    int          stall_cyc;
    int          loads_before;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i); #1;
        chk("rst_tx_cs", 32'(tx_cs_o), 32'd0);
        chk("rst_br", 32'(tx_byte_ready_o), 32'd0);
        chk("rst_start", 32'(tx_start_o), 32'd0);
        chk("rst_tx_data", 32'(tx_data_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_rdata_nocs", rdata_o, 32'd0);
        bus_rd(2'd1, rd); chk("rst_status", rd, 32'h1);
        bus_rd(2'd2, rd); chk("rst_ctrl", rd, 32'h1);
        bus_rd(2'd3, rd); chk("reserved_rd", rd, 32'h0);

        // Single byte
        sb_q.push_back(8'h41);
        bus_wr(2'd0, 32'h41);
        w = cyc - 1;
        repeat (4) @(negedge clk_i);
        #1;
        chk("load_latency", 32'(last_br_cyc - w), 32'd2);
        bus_rd(2'd1, rd); chk("busy_status", rd, 32'h5);
        wait_status(32'h1, 60, "idle_after_byte");

        // Disabled fill to full
        bus_wr(2'd2, 32'h0);
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(8'(i));
            bus_wr(2'd0, 32'(i));
        end
        bus_rd(2'd1, rd); chk("full_status", rd, 32'h802);

        // Non-blocking overflow, then clear
        bus_wr(2'd0, 32'hFF);
        bus_rd(2'd1, rd); chk("ovf_status", rd, 32'h80A);
        bus_wr(2'd1, 32'hFFFF_FFFF);
        bus_wr(2'd3, 32'h1F);
        bus_rd(2'd1, rd); chk("ignored_writes", rd, 32'h80A);
        bus_wr(2'd2, 32'h8);
        bus_rd(2'd1, rd); chk("ovf_cleared", rd, 32'h802);
        bus_rd(2'd2, rd); chk("ctrl_pulse_reads0", rd, 32'h0);

        // Enable with block_on_full; refill and stall on a full FIFO
        gap_mode  = 1'b1;
        gap_dones = 0;
        bus_wr(2'd2, 32'h5);
        sb_q.push_back(8'h08);
        bus_wr(2'd0, 32'h08);
        @(negedge clk_i);
        cs_i = 1'b1; we_i = 1'b1; addr_i = 2'd0; wdata_i = 32'h55;
        #1;
        stall_cyc = 0;
        while (stall_o && stall_cyc < 200) begin
            @(negedge clk_i); #1;
            stall_cyc++;
        end
        chk("stall_released", 32'(stall_o), 32'd0);
        chk("stall_seen", 32'(stall_cyc > 5), 32'd1);
        chk("stall_drop_at_pop", 32'(tx_byte_ready_o), 32'd1);
        sb_q.push_back(8'h55);
        @(negedge clk_i);
        cs_i = 1'b0; we_i = 1'b0; wdata_i = 32'd0;
        wait_status(32'h1, 400, "drain_all");
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        gap_mode = 1'b0;
        bus_rd(2'd2, rd); chk("ctrl_rw", rd, 32'h5);

        // Flush mid-transfer
        bus_wr(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(8'(8'h10 + i));
            bus_wr(2'd0, 32'(32'h10 + i));
        end
        repeat (3) @(negedge clk_i);
        bus_wr(2'd2, 32'h11);
        sb_q.delete();
        loads_before = n_loads;
        bus_rd(2'd1, rd); chk("flush_status", rd, 32'h5);
        bus_rd(2'd2, rd); chk("flush_ctrl", rd, 32'h1);
        wait_status(32'h1, 60, "flush_done");
        repeat (10) @(negedge clk_i);
        chk("flush_no_load", 32'(n_loads - loads_before), 32'd0);

        // Interrupt timing
        bus_wr(2'd2, 32'h3);
        repeat (2) @(negedge clk_i);
        #1;
        chk("irq_idle", 32'(irq_o), 32'd1);
        sb_q.push_back(8'h66);
        bus_wr(2'd0, 32'h66);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i); #1;
            if (tx_start_o) break;
        end
        chk("irq_start_seen", 32'(tx_start_o), 32'd1);
        chk("irq_busy", 32'(irq_o), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i); #1;
            if (tx_done_i) break;
        end
        chk("irq_done_seen", 32'(tx_done_i), 32'd1);
        @(negedge clk_i); #1;
        chk("irq_lag0", 32'(irq_o), 32'd0);
        @(negedge clk_i); #1;
        chk("irq_lag1", 32'(irq_o), 32'd1);

        // Reset during WAIT
        sb_q.push_back(8'h77);
        bus_wr(2'd0, 32'h77);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i); #1;
            if (tx_start_o) break;
        end
        chk("rst_start_seen", 32'(tx_start_o), 32'd1);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i); #1;
        chk("midrst_tx_cs", 32'(tx_cs_o), 32'd0);
        chk("midrst_br", 32'(tx_byte_ready_o), 32'd0);
        chk("midrst_start", 32'(tx_start_o), 32'd0);
        chk("midrst_tx_data", 32'(tx_data_o), 32'd0);
        chk("midrst_irq", 32'(irq_o), 32'd0);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        bus_rd(2'd1, rd); chk("midrst_status", rd, 32'h1);
        bus_rd(2'd2, rd); chk("midrst_ctrl", rd, 32'h1);
        repeat (25) @(negedge clk_i);
        bus_rd(2'd1, rd); chk("late_done_ignored", rd, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
